// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold: registered one-hot grant plus binary index.
// Define PARAMMOD_ARB_TIMEOUT_EN to add a hold-time watchdog that revokes stuck grants.
module rr_arbiter #(
  parameter  int REQ      = 8,
  parameter  int MAX_HOLD = 16,
  localparam int OUT      = $clog2(REQ)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [REQ-1:0] req,
  input  logic           done,
  output logic [REQ-1:0] grant,
  output logic [OUT-1:0] grant_id,
  output logic           busy,
  output logic           timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state_reg, state_next;
  logic [OUT-1:0] ptr_reg, ptr_next, ptr_inc, arb_ptr;
  logic [REQ-1:0] grant_reg, grant_next;
  logic [OUT-1:0] grant_id_reg, grant_id_next;
  logic           busy_reg, busy_next;
  logic           timeout_reg, timeout_next;

  logic [REQ-1:0] masked, win_onehot;
  logic [OUT-1:0] masked_id, req_id, win_id;
  logic           any_req, owner_req, expire, release_ev, forced_ev, load;

  if (REQ < 2) begin : g_bad_req
    $error("rr_arbiter: REQ must be >= 2");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("rr_arbiter: MAX_HOLD must be >= 2");
  end

  assign any_req    = |req;
  assign owner_req  = req[grant_id_reg];
  assign ptr_inc    = (grant_id_reg == OUT'(REQ - 1)) ? '0 : grant_id_reg + OUT'(1);
  assign release_ev = (state_reg == GRANT) && (done || !owner_req || expire);
  assign forced_ev  = expire && !done && owner_req;
  assign load       = any_req && ((state_reg == IDLE) || release_ev);

  // On a release the search already uses the advanced pointer, so the old owner is last.
  assign arb_ptr = release_ev ? ptr_inc : ptr_reg;

  for (genvar gi = 0; gi < REQ; gi++) begin : g_mask
    assign masked[gi]     = req[gi] && (OUT'(gi) >= arb_ptr);
    assign win_onehot[gi] = (win_id == OUT'(gi));
  end

  always_comb begin
    masked_id = '0;
    req_id    = '0;
    for (int i = REQ - 1; i >= 0; i--) begin
      if (masked[i]) masked_id = OUT'(i);
      if (req[i])    req_id    = OUT'(i);
    end
  end

  assign win_id = (|masked) ? masked_id : req_id;

`ifdef PARAMMOD_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);

  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;

  assign expire = (state_reg == GRANT) && (hold_cnt_reg == HW'(MAX_HOLD - 1));

  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (load || release_ev)
      hold_cnt_next = '0;
    else if (state_reg == GRANT)
      hold_cnt_next = hold_cnt_reg + HW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      hold_cnt_reg <= '0;
    else
      hold_cnt_reg <= hold_cnt_next;
  end
`else
  assign expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      busy_reg     <= busy_next;
      timeout_reg  <= timeout_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) state_next = GRANT;
      end
      GRANT: begin
        if (release_ev) begin
          ptr_next   = ptr_inc;
          state_next = any_req ? GRANT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic (feeds the output registers)
  always_comb begin
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    busy_next     = (state_next == GRANT);
    timeout_next  = release_ev && forced_ev;
    if (load) begin
      grant_next    = win_onehot;
      grant_id_next = win_id;
    end else if (release_ev || state_reg == IDLE) begin
      grant_next = '0;
    end
  end

  assign grant    = grant_reg;
  assign grant_id = grant_id_reg;
  assign busy     = busy_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed scenarios plus random traffic
// compared every cycle against a rotating-search reference model.
module tb_rr_arbiter;
  localparam int REQ      = 8;
  localparam int MAX_HOLD = 4;
  localparam int OUT      = $clog2(REQ);
`ifdef PARAMMOD_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk;
  logic           reset_n;
  logic [REQ-1:0] req;
  logic           done;
  logic [REQ-1:0] grant;
  logic [OUT-1:0] grant_id;
  logic           busy;
  logic           timeout;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Reference model: owner index (-1 when idle), priority start, hold length.
  int m_owner, m_ptr, m_hold, m_gid;
  bit m_timeout;

  rr_arbiter #(.REQ(REQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done),
    .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // First requester found scanning upward from p with wrap-around.
  function automatic int win_of(input logic [REQ-1:0] r, input int p);
    for (int k = 0; k < REQ; k++) begin
      if (r[(p + k) % REQ]) return (p + k) % REQ;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    int w;
    int np;
    bit expire;
    if (!reset_n) begin
      m_owner   <= -1;
      m_ptr     <= 0;
      m_hold    <= 0;
      m_gid     <= 0;
      m_timeout <= 1'b0;
    end else begin
      m_timeout <= 1'b0;
      if (m_owner < 0) begin
        w = win_of(req, m_ptr);
        if (w >= 0) begin
          m_owner <= w;
          m_gid   <= w;
          m_hold  <= 0;
        end
      end else begin
        expire = TO_EN && (m_hold == MAX_HOLD - 1);
        if (done || !req[m_owner] || expire) begin
          np = (m_owner + 1) % REQ;
          w  = win_of(req, np);
          m_ptr     <= np;
          m_owner   <= w;
          m_hold    <= 0;
          m_timeout <= expire && !done && req[m_owner];
          if (w >= 0) m_gid <= w;
        end else begin
          m_hold <= m_hold + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en && reset_n) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_owner >= 0});
      chk("cyc_grant", {24'd0, grant}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("cyc_timeout", {31'd0, timeout}, {31'd0, m_timeout});
      if (m_owner >= 0) chk("cyc_grant_id", {29'd0, grant_id}, m_gid);
      $display("cyc t=%0t req=%02h done=%0b grant=%02h id=%0d busy=%0b to=%0b",
               $time, req, done, grant, grant_id, busy, timeout);
    end
  end

  task automatic step(input logic [REQ-1:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    req     = '0;
    done    = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", {24'd0, grant}, 32'h0);
    chk("rst_grant_id", {29'd0, grant_id}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_timeout", {31'd0, timeout}, 32'h0);
    reset_n  = 1'b1;
    check_en = 1'b1;

    repeat (10) step(8'h00, 1'b0);
    chk("idle_busy", {31'd0, busy}, 32'h0);

    step(8'h05, 1'b0);
    chk("first_grant", {24'd0, grant}, 32'h01);
    chk("first_id", {29'd0, grant_id}, 32'd0);
    step(8'h05, 1'b0);
    step(8'h05, 1'b0);
    step(8'h05, 1'b1);
    chk("handoff_grant", {24'd0, grant}, 32'h04);
    chk("handoff_id", {29'd0, grant_id}, 32'd2);
    chk("handoff_busy", {31'd0, busy}, 32'h1);
    step(8'h05, 1'b1);
    chk("return_grant", {24'd0, grant}, 32'h01);

    do_reset();
    step(8'hFF, 1'b1);
    chk("rot_id_0", {29'd0, grant_id}, 32'd0);
    for (int k = 1; k <= REQ; k++) begin
      step(8'hFF, 1'b1);
      chk("rot_id", {29'd0, grant_id}, k % REQ);
    end

    do_reset();
    step(8'h08, 1'b0);
    chk("own3_id", {29'd0, grant_id}, 32'd3);
    step(8'h02, 1'b0);
    chk("withdraw_grant", {24'd0, grant}, 32'h02);
    chk("model_ptr", m_ptr, 32'd4);
    step(8'h02, 1'b1);
    chk("regrant_grant", {24'd0, grant}, 32'h02);
    chk("regrant_id", {29'd0, grant_id}, 32'd1);

    #1 reset_n = 1'b0;
    #1;
    chk("async_grant", {24'd0, grant}, 32'h0);
    chk("async_busy", {31'd0, busy}, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    step(8'h03, 1'b0);
    chk("wd_first", {24'd0, grant}, 32'h01);
`ifdef PARAMMOD_ARB_TIMEOUT_EN
    for (int k = 0; k < MAX_HOLD - 1; k++) begin
      step(8'h03, 1'b0);
      chk("wd_hold", {24'd0, grant}, 32'h01);
      chk("wd_hold_to", {31'd0, timeout}, 32'h0);
    end
    step(8'h03, 1'b0);
    chk("wd_revoke_grant", {24'd0, grant}, 32'h02);
    chk("wd_revoke_to", {31'd0, timeout}, 32'h1);
    chk("model_timeout", {31'd0, m_timeout}, 32'h1);
    step(8'h03, 1'b0);
    chk("wd_pulse_end", {31'd0, timeout}, 32'h0);
`else
    repeat (100) step(8'h03, 1'b0);
    chk("hold_grant", {24'd0, grant}, 32'h01);
    chk("hold_to", {31'd0, timeout}, 32'h0);
`endif

    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [REQ-1:0] r;
      r = REQ'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & REQ'($urandom);
      if ($urandom_range(0, 9) == 0) r = '0;
      step(r, ($urandom_range(0, 3) == 0));
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter with grant hold that shares one resource among REQ requesters. It registers a one-hot grant plus its binary index for the shared datapath mux, which is typically a `selector` in vector mode fed by the index. The grant is held until the owner signals completion, or withdraws its request. Fairness comes from a rotating priority pointer: the last owner always drops to lowest priority. An optional hold-time watchdog forcibly revokes a stuck grant.

## Interface
- `REQ`, 8: number of requesters; must be ≥ 2.
- `MAX_HOLD`, 16: maximum grant length in cycles, used only with the watchdog; must be ≥ 2.
- `OUT`, `$clog2(REQ)`: index width; derived, not overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `req`  in  REQ  request per requester; active-high; level-sensitive.
- `done`  in  1  owner finished; sampled only while `busy`=1.
- `grant`  out  REQ  one-hot grant, registered; all-zero when idle.
- `grant_id`  out  OUT  binary index of the current owner, registered; valid only while `busy`=1.
- `busy`  out  1  a grant is active; registered; equals `|grant`.
- `timeout`  out  1  one-cycle pulse when the watchdog revokes a grant; constant 0 without the macro.

## Operation
- Reset values:
  - `grant`=0, `grant_id`=0, `busy`=0, `timeout`=0.
  - Priority pointer `ptr`=0, state IDLE, hold counter 0.
- States:
  - IDLE: no owner.
  - GRANT: one owner, held.
- Arbitration function, evaluated combinationally each cycle:
  - Masked vector = `req` with bits below `ptr` cleared.
  - If the masked vector is nonzero, the winner is its lowest set bit; otherwise the winner is the lowest set bit of `req`.
  - Both searches are LSB-first priority encodes.
- IDLE → GRANT: when `|req`=1, load `grant`/`grant_id` with the winner and set `busy`. Otherwise stay idle.
- GRANT, release event:
  - A release occurs when `done`=1, or when `req[grant_id]`=0 (the owner withdrew), or on watchdog expiry.
  - On release, `ptr` ← (`grant_id`+1) mod REQ, wrapping from REQ-1 to 0.
  - The next winner is computed using that new `ptr` value and the current `req` with the owner's bit still included.
  - If a winner exists, go directly to a new GRANT with no idle bubble; otherwise go to IDLE.
- GRANT, no release: `grant` and `grant_id` stay stable, regardless of changes on other `req` bits.
- The owner re-requests on its own release cycle: it has lowest priority and wins only if no other request is set.
- `ptr` changes only on release, never on the initial IDLE→GRANT transition.
- `done` is ignored in IDLE.

## Timing
- Grant latency: `req` rising in IDLE at cycle N gives `grant` valid at N+1.
- Handoff: release at cycle M gives the new `grant` at M+1, or IDLE at M+1.
- There is exactly one owner per cycle, with no overlap and no gap between back-to-back owners.
- `reset_n` asserted mid-grant clears all state immediately (asynchronously) and drops `grant` without waiting for `done`.
- The first rising edge after deassertion behaves as IDLE.
- Outputs are registered only; there is no combinational path from `req`/`done` to any output.

## Configuration
- `PARAMMOD_ARB_TIMEOUT_EN` defined:
  - A hold counter clears on every new grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 without a release, that cycle is a forced release, and `timeout` pulses high for exactly 1 cycle, registered, coincident with the new `grant`.
  - `done` in the same cycle as expiry is a normal release, and no `timeout` pulse is generated.
- Undefined: no counter is instantiated, `timeout` is tied to 0, and a grant is held indefinitely.

## Test plan
- Reset → all outputs 0. `req`=8'h00 for 10 cycles → `busy` stays 0.
- `req`=8'h05 in IDLE at cycle 0 → `grant`=8'h01, `grant_id`=0 at cycle 1. `done` at cycle 3 → `grant`=8'h04, `grant_id`=2 at cycle 4 with no bubble. `done` with `req`=8'h05 held → `grant` returns to 8'h01.
- `req`=8'hFF held with `done` every cycle → `grant_id` sequence 0,1,…,7,0: fair rotation with wrap-around.
- `grant_id`=3, owner drops `req[3]` while `req`=8'h02 → next cycle `grant`=8'h02 and `ptr`=4.
- Owner 1 releases with `req`=8'h02 only → owner 1 is re-granted the next cycle. Assert `reset_n`=0 mid-grant → `grant` is 0 immediately, without waiting for a clock edge.
- With the macro and MAX_HOLD=4, `req`=8'h03, no `done` → owner 0 holds for 4 cycles, then `timeout`=1 for one cycle and `grant`=8'h02. Without the macro → owner 0 holds for 100 cycles and `timeout` stays 0.
